// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
//   Shared definitions for the rename register file:
//     - default data / ROB tag widths
//     - 6-bit opcode encodings seen at issue
//     - operand_t: one source operand as delivered to a reservation station
//       (value, producing ROB tag, value-valid flag)
//     - writes_rd(): true for opcodes that produce a destination register
// ---------------------------------------------------------------------------
package rob_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int ROB_TAG_W_DEF = 3;
  localparam int OP_W          = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 6'h01;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h02;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h03;
  localparam logic [OP_W-1:0] OP_SLL  = 6'h04;
  localparam logic [OP_W-1:0] OP_SRL  = 6'h05;
  localparam logic [OP_W-1:0] OP_MUL  = 6'h06;
  localparam logic [OP_W-1:0] OP_LW   = 6'h07;
  localparam logic [OP_W-1:0] OP_SW   = 6'h08;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h09;
  localparam logic [OP_W-1:0] OP_LI   = 6'h0A;

  // One source operand. When rdy is 0 the value is not yet known and q
  // names the ROB entry the reservation station must wait on.
  typedef struct packed {
    logic [XLEN_DEF-1:0]      v;
    logic [ROB_TAG_W_DEF-1:0] q;
    logic                     rdy;
  } operand_t;

  // sw and bne have no destination; unknown opcodes never rename.
  function automatic logic writes_rd(input logic [OP_W-1:0] op);
    logic res;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SLL, OP_SRL, OP_MUL, OP_LW, OP_LI: res = 1'b1;
      default:                                                       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rename_table.sv
// ---------------------------------------------------------------------------
// rename_table
//   Per-register rename status: a busy bit and the ROB tag of the youngest
//   in-flight producer. Two combinational read ports serve the two issue
//   sources.
//
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     i_flush                    clear every busy bit (tags are left as-is)
//     i_ren_en/i_ren_idx/i_ren_tag  rename one register to a new ROB tag
//     i_cmt_valid/i_cmt_idx/i_cmt_tag  commit; clears busy only on tag match
//     i_rd_a_idx, i_rd_b_idx     read port indices
//     o_rd_a_busy/o_rd_a_tag     read port A status
//     o_rd_b_busy/o_rd_b_tag     read port B status
// ---------------------------------------------------------------------------
module rename_table
  import rob_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int REG_IDX_W = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_ren_en,
  input  logic [REG_IDX_W-1:0] i_ren_idx,
  input  logic [ROB_TAG_W-1:0] i_ren_tag,
  input  logic                 i_cmt_valid,
  input  logic [REG_IDX_W-1:0] i_cmt_idx,
  input  logic [ROB_TAG_W-1:0] i_cmt_tag,
  input  logic [REG_IDX_W-1:0] i_rd_a_idx,
  input  logic [REG_IDX_W-1:0] i_rd_b_idx,
  output logic                 o_rd_a_busy,
  output logic [ROB_TAG_W-1:0] o_rd_a_tag,
  output logic                 o_rd_b_busy,
  output logic [ROB_TAG_W-1:0] o_rd_b_tag
);

  logic [NREGS-1:0]     r_busy;
  logic [ROB_TAG_W-1:0] r_tag [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int r = 0; r < NREGS; r++) r_tag[r] <= '0;
    end else if (i_flush) begin
      // A flush discards every pending producer; any same-cycle rename has
      // already been suppressed by the caller.
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        // Only the youngest producer may clear busy: a stale commit (older
        // tag) leaves the newer rename in place.
        if (i_cmt_valid && (i_cmt_idx == REG_IDX_W'(r)) && (r_tag[r] == i_cmt_tag))
          r_busy[r] <= 1'b0;
        // Rename is evaluated last so it wins over a same-cycle commit.
        if (i_ren_en && (i_ren_idx == REG_IDX_W'(r))) begin
          r_busy[r] <= 1'b1;
          r_tag[r]  <= i_ren_tag;
        end
      end
    end
  end

  assign o_rd_a_busy = r_busy[i_rd_a_idx];
  assign o_rd_a_tag  = r_tag[i_rd_a_idx];
  assign o_rd_b_busy = r_busy[i_rd_b_idx];
  assign o_rd_b_tag  = r_tag[i_rd_b_idx];

endmodule

// File: rtl/rename_regfile.sv
// ---------------------------------------------------------------------------
// rename_regfile
//   Architectural register file with rename status for the Tomasulo core.
//   At issue it resolves both source operands (value or producing ROB tag),
//   renames the destination, and registers the operand bundle for the
//   reservation stations. ROB commits write architectural values back and
//   may bypass straight into a same-cycle issue.
//
//   Handshake (both sides): a transfer happens on valid & ready. iss_ready =
//   !out_valid | out_ready, so the single output stage can be refilled in the
//   same cycle it is drained. While out_valid & !out_ready the bundle holds.
//
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     iss_valid/iss_ready              issue handshake
//     iss_op/rs1/rs2/rd/imm/rob_tag    issued instruction fields
//     out_valid/out_ready              operand bundle handshake
//     out_v1/v2, out_q1/q2, out_rdy1/2 resolved operands
//     out_offset                       address offset (lw/sw), else 0
//     cmt_valid/idx/data/tag           ROB commit
//     flush                            mispredict flush
// ---------------------------------------------------------------------------
module rename_regfile
  import rob_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = 32,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int REG_IDX_W = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [OP_W-1:0]      iss_op,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic [XLEN-1:0]      iss_imm,
  input  logic [ROB_TAG_W-1:0] iss_rob_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_v1,
  output logic [XLEN-1:0]      out_v2,
  output logic [ROB_TAG_W-1:0] out_q1,
  output logic [ROB_TAG_W-1:0] out_q2,
  output logic                 out_rdy1,
  output logic                 out_rdy2,
  output logic [XLEN-1:0]      out_offset,
  input  logic                 cmt_valid,
  input  logic [REG_IDX_W-1:0] cmt_idx,
  input  logic [XLEN-1:0]      cmt_data,
  input  logic [ROB_TAG_W-1:0] cmt_tag,
  input  logic                 flush
);

  logic [XLEN-1:0]      r_regs [NREGS];
  logic                 r_out_valid;
  operand_t             r_op1;
  operand_t             r_op2;
  logic [XLEN-1:0]      r_offset;

  logic                 w_accept;
  logic                 w_ren_en;
  logic [REG_IDX_W-1:0] w_src_b_idx;
  logic                 w_busy_a;
  logic                 w_busy_b;
  logic [ROB_TAG_W-1:0] w_tag_a;
  logic [ROB_TAG_W-1:0] w_tag_b;
  operand_t             w_src_a;
  operand_t             w_src_b;
  operand_t             w_op1;
  operand_t             w_op2;
  logic [XLEN-1:0]      w_offset;

  assign iss_ready = !r_out_valid || out_ready;
  // A flush drops the issue entirely: no bundle and no rename.
  assign w_accept  = iss_valid && iss_ready && !flush;
  assign w_ren_en  = w_accept && writes_rd(iss_op) && (iss_rd != '0);

  // lw takes its base address from rs1 but delivers it in slot 2.
  assign w_src_b_idx = (iss_op == OP_LW) ? iss_rs1 : iss_rs2;

  rename_table #(
    .NREGS     (NREGS),
    .ROB_TAG_W (ROB_TAG_W),
    .REG_IDX_W (REG_IDX_W)
  ) u_rename_table (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_ren_en    (w_ren_en),
    .i_ren_idx   (iss_rd),
    .i_ren_tag   (iss_rob_tag),
    .i_cmt_valid (cmt_valid),
    .i_cmt_idx   (cmt_idx),
    .i_cmt_tag   (cmt_tag),
    .i_rd_a_idx  (iss_rs1),
    .i_rd_b_idx  (w_src_b_idx),
    .o_rd_a_busy (w_busy_a),
    .o_rd_a_tag  (w_tag_a),
    .o_rd_b_busy (w_busy_b),
    .o_rd_b_tag  (w_tag_b)
  );

  // Resolve one register source. The lookup sees the mapping from before
  // this instruction's own rename, so rs == rd reads the previous producer.
  function automatic operand_t lookup(input logic [REG_IDX_W-1:0] idx,
                                      input logic                 busy,
                                      input logic [ROB_TAG_W-1:0] tag,
                                      input logic [XLEN-1:0]      regval,
                                      input logic                 c_valid,
                                      input logic [REG_IDX_W-1:0] c_idx,
                                      input logic [ROB_TAG_W-1:0] c_tag,
                                      input logic [XLEN-1:0]      c_data);
    operand_t res;
    res = '0;
    if (idx == '0) begin
      res.rdy = 1'b1;
    end else if (!busy) begin
      res.rdy = 1'b1;
      res.v   = regval;
    end else if (c_valid && (c_idx == idx) && (c_tag == tag)) begin
      // Producer commits this very cycle: forward its data.
      res.rdy = 1'b1;
      res.v   = c_data;
    end else begin
      res.q = tag;
    end
    return res;
  endfunction

  always_comb begin
    w_src_a = lookup(iss_rs1, w_busy_a, w_tag_a, r_regs[iss_rs1],
                     cmt_valid, cmt_idx, cmt_tag, cmt_data);
    w_src_b = lookup(w_src_b_idx, w_busy_b, w_tag_b, r_regs[w_src_b_idx],
                     cmt_valid, cmt_idx, cmt_tag, cmt_data);
  end

  // Operand selection by opcode; unused slots are ready with value 0.
  always_comb begin
    w_op1     = '0;
    w_op1.rdy = 1'b1;
    w_op2     = '0;
    w_op2.rdy = 1'b1;
    w_offset  = '0;
    case (iss_op)
      OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_MUL, OP_BNE: begin
        w_op1 = w_src_a;
        w_op2 = w_src_b;
      end
      OP_ADDI: begin
        w_op1   = w_src_a;
        w_op2.v = iss_imm;
      end
      OP_LW: begin
        w_op2    = w_src_b;
        w_offset = iss_imm;
      end
      OP_SW: begin
        w_op1    = w_src_a;
        w_op2    = w_src_b;
        w_offset = iss_imm;
      end
      OP_LI: begin
        w_op2.v = iss_imm;
      end
      default: ;
    endcase
  end

  // Architectural data. Commits still land during a flush; r0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else if (cmt_valid && (cmt_idx != '0)) begin
      r_regs[cmt_idx] <= cmt_data;
    end
  end

  // Output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_offset    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_offset    <= w_offset;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_v1     = r_op1.v;
  assign out_q1     = r_op1.q;
  assign out_rdy1   = r_op1.rdy;
  assign out_v2     = r_op2.v;
  assign out_q2     = r_op2.q;
  assign out_rdy2   = r_op2.rdy;
  assign out_offset = r_offset;

endmodule

// File: tb/tb_rename_regfile.sv
// ---------------------------------------------------------------------------
// tb_rename_regfile
//   Directed self-checking bench for rename_regfile. Inputs change 1 ns
//   after the rising edge; outputs are sampled at the same point, i.e. after
//   the edge that registered them.
// ---------------------------------------------------------------------------
module tb_rename_regfile;
  import rob_pkg::*;

  localparam logic [5:0] OP_BAD = 6'h3F;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_op;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic [31:0] iss_imm;
  logic [2:0]  iss_rob_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_v1;
  logic [31:0] out_v2;
  logic [2:0]  out_q1;
  logic [2:0]  out_q2;
  logic        out_rdy1;
  logic        out_rdy2;
  logic [31:0] out_offset;
  logic        cmt_valid;
  logic [4:0]  cmt_idx;
  logic [31:0] cmt_data;
  logic [2:0]  cmt_tag;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  rename_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_op      (iss_op),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_rd      (iss_rd),
    .iss_imm     (iss_imm),
    .iss_rob_tag (iss_rob_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_v1      (out_v1),
    .out_v2      (out_v2),
    .out_q1      (out_q1),
    .out_q2      (out_q2),
    .out_rdy1    (out_rdy1),
    .out_rdy2    (out_rdy2),
    .out_offset  (out_offset),
    .cmt_valid   (cmt_valid),
    .cmt_idx     (cmt_idx),
    .cmt_data    (cmt_data),
    .cmt_tag     (cmt_tag),
    .flush       (flush)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bundle(input string tag, input logic valid,
                              input logic [31:0] v1, input logic rdy1, input logic [2:0] q1,
                              input logic [31:0] v2, input logic rdy2, input logic [2:0] q2,
                              input logic [31:0] off);
    check({tag, ".valid"}, 32'(out_valid), 32'(valid));
    check({tag, ".v1"},    out_v1,         v1);
    check({tag, ".rdy1"},  32'(out_rdy1),  32'(rdy1));
    check({tag, ".q1"},    32'(out_q1),    32'(q1));
    check({tag, ".v2"},    out_v2,         v2);
    check({tag, ".rdy2"},  32'(out_rdy2),  32'(rdy2));
    check({tag, ".q2"},    32'(out_q2),    32'(q2));
    check({tag, ".off"},   out_offset,     off);
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [2:0] tag);
    iss_valid   = 1'b1;
    iss_op      = op;
    iss_rd      = rd;
    iss_rs1     = rs1;
    iss_rs2     = rs2;
    iss_imm     = imm;
    iss_rob_tag = tag;
  endtask

  task automatic no_issue();
    iss_valid = 1'b0;
  endtask

  task automatic commit(input logic [4:0] idx, input logic [31:0] data, input logic [2:0] tag);
    cmt_valid = 1'b1;
    cmt_idx   = idx;
    cmt_data  = data;
    cmt_tag   = tag;
  endtask

  task automatic no_commit();
    cmt_valid = 1'b0;
  endtask

  // Issue for exactly one edge.
  task automatic issue_one(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic [2:0] tag);
    issue(op, rd, rs1, rs2, imm, tag);
    tick();
    no_issue();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    iss_valid = 1'b0; iss_op = '0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    iss_imm = '0; iss_rob_tag = '0;
    cmt_valid = 1'b0; cmt_idx = '0; cmt_data = '0; cmt_tag = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_bundle("reset", 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    check("reset.iss_ready", 32'(iss_ready), 1);

    // add r1,r2,r3 tag 5 on fresh registers, then observe r1 renamed to 5
    issue_one(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 3'd5);
    check_bundle("add_fresh", 1'b1, 0, 1'b1, 0, 0, 1'b1, 0, 0);
    issue_one(OP_ADD, 5'd8, 5'd1, 5'd0, 32'd0, 3'd6);
    check_bundle("r1_busy", 1'b1, 0, 1'b0, 3'd5, 0, 1'b1, 0, 0);

    // addi r5,r0,7 tag 2; add r6,r5,r5 waits on tag 2
    issue_one(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd7, 3'd2);
    check_bundle("addi", 1'b1, 0, 1'b1, 0, 32'd7, 1'b1, 0, 0);
    issue_one(OP_ADD, 5'd6, 5'd5, 5'd5, 32'd0, 3'd3);
    check_bundle("add_dep", 1'b1, 0, 1'b0, 3'd2, 0, 1'b0, 3'd2, 0);

    // Commit r5 = 7 (tag 2) with no issue: out_valid drains
    commit(5'd5, 32'd7, 3'd2);
    tick();
    no_commit();
    check("drain.valid", 32'(out_valid), 0);
    issue_one(OP_ADD, 5'd9, 5'd5, 5'd0, 32'd0, 3'd4);
    check_bundle("r5_committed", 1'b1, 32'd7, 1'b1, 0, 0, 1'b1, 0, 0);

    // Commit to r0 is ignored
    commit(5'd0, 32'hDEAD, 3'd0);
    tick();
    no_commit();
    issue_one(OP_ADD, 5'd20, 5'd0, 5'd0, 32'd0, 3'd0);
    check_bundle("r0_zero", 1'b1, 0, 1'b1, 0, 0, 1'b1, 0, 0);

    // lw r19, 12(r5): base in slot 2, slot 1 unused
    issue_one(OP_LW, 5'd19, 5'd5, 5'd0, 32'd12, 3'd1);
    check_bundle("lw", 1'b1, 0, 1'b1, 0, 32'd7, 1'b1, 0, 32'd12);

    // Unknown opcode: both operands ready with value 0
    issue_one(OP_BAD, 5'd21, 5'd5, 5'd5, 32'd5, 3'd1);
    check_bundle("unknown_op", 1'b1, 0, 1'b1, 0, 0, 1'b1, 0, 0);

    // Same-cycle bypass: r4 busy with tag 3, commit (r4,99,3) with sw r4,r4,8
    issue_one(OP_LI, 5'd4, 5'd0, 5'd0, 32'd0, 3'd3);
    commit(5'd4, 32'd99, 3'd3);
    issue_one(OP_SW, 5'd0, 5'd4, 5'd4, 32'd8, 3'd7);
    no_commit();
    check_bundle("bypass_sw", 1'b1, 32'd99, 1'b1, 0, 32'd99, 1'b1, 0, 32'd8);
    issue_one(OP_ADD, 5'd10, 5'd4, 5'd0, 32'd0, 3'd0);
    check_bundle("r4_after_sw", 1'b1, 32'd99, 1'b1, 0, 0, 1'b1, 0, 0);

    // Stale commit: r7 -> tag 1 -> tag 4; commit (r7,5,tag 1) keeps busy/tag 4
    issue_one(OP_LI, 5'd7, 5'd0, 5'd0, 32'd0, 3'd1);
    issue_one(OP_LI, 5'd7, 5'd0, 5'd0, 32'd0, 3'd4);
    commit(5'd7, 32'd5, 3'd1);
    tick();
    no_commit();
    issue_one(OP_ADD, 5'd11, 5'd7, 5'd0, 32'd0, 3'd0);
    check_bundle("stale_commit", 1'b1, 0, 1'b0, 3'd4, 0, 1'b1, 0, 0);

    // Backpressure
    issue_one(OP_ADDI, 5'd12, 5'd0, 5'd0, 32'h55, 3'd2);
    out_ready = 1'b0;
    issue(OP_ADDI, 5'd13, 5'd0, 5'd0, 32'h66, 3'd5);
    #1;
    check("bp.iss_ready0", 32'(iss_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp.hold%0d.valid", i), 32'(out_valid), 1);
      check($sformatf("bp.hold%0d.v2", i), out_v2, 32'h55);
      check($sformatf("bp.hold%0d.iss_ready", i), 32'(iss_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.iss_ready1", 32'(iss_ready), 1);
    tick();
    no_issue();
    check("bp.next.valid", 32'(out_valid), 1);
    check("bp.next.v2", out_v2, 32'h66);

    // Flush with concurrent issue and commit (r15 = 0x1234 still written)
    flush = 1'b1;
    issue(OP_LI, 5'd14, 5'd0, 5'd0, 32'h77, 3'd6);
    commit(5'd15, 32'h1234, 3'd0);
    tick();
    flush = 1'b0;
    no_issue();
    no_commit();
    check("flush.valid", 32'(out_valid), 0);
    check("flush.v2_not_li", out_v2, 32'h66);
    issue_one(OP_ADD, 5'd16, 5'd7, 5'd14, 32'd0, 3'd1);
    check_bundle("post_flush_r7", 1'b1, 32'd5, 1'b1, 0, 0, 1'b1, 0, 0);
    issue_one(OP_ADD, 5'd17, 5'd1, 5'd15, 32'd0, 3'd2);
    check_bundle("post_flush_r1", 1'b1, 0, 1'b1, 0, 32'h1234, 1'b1, 0, 0);

    // Reset mid-stream overrides issue and commit
    rst = 1'b1;
    issue(OP_LI, 5'd18, 5'd0, 5'd0, 32'd9, 3'd3);
    commit(5'd15, 32'hAAAA, 3'd0);
    tick();
    rst = 1'b0;
    no_issue();
    no_commit();
    check_bundle("rst_mid", 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    issue_one(OP_ADD, 5'd22, 5'd15, 5'd18, 32'd0, 3'd0);
    check_bundle("rst_r15_r18", 1'b1, 0, 1'b1, 0, 0, 1'b1, 0, 0);
    issue_one(OP_ADD, 5'd23, 5'd5, 5'd4, 32'd0, 3'd0);
    check_bundle("rst_r5_r4", 1'b1, 0, 1'b1, 0, 0, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename status (busy bit plus ROB tag) for the Tomasulo core.
- Sits between decode and the reservation stations.
- At issue it reads the source operands for one instruction and returns, per source, either a ready value or the ROB tag that will produce it. In the same cycle it renames the destination to a new ROB tag.
- ROB commit writes architectural values back. A flush clears all pending renames.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- ROB_TAG_W, 3, ROB tag width (ROB depth = 2**ROB_TAG_W).
- REG_IDX_W, $clog2(NREGS), register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- iss_valid  in  1  issue request.
- iss_ready  out  1  = !out_valid | out_ready.
- iss_op  in  6  opcode (add/addi/sub/sll/srl/mul/lw/sw/bne/li encodings, from package).
- iss_rs1, iss_rs2, iss_rd  in  REG_IDX_W  source and destination registers.
- iss_imm  in  XLEN  immediate.
- iss_rob_tag  in  ROB_TAG_W  ROB entry allocated to this instruction.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  reservation station accepts the bundle.
- out_v1, out_v2  out  XLEN  operand values.
- out_q1, out_q2  out  ROB_TAG_W  producing tag when the operand is not ready.
- out_rdy1, out_rdy2  out  1  operand value valid.
- out_offset  out  XLEN  address offset for lw/sw, else 0.
- cmt_valid  in  1  ROB commit.
- cmt_idx  in  REG_IDX_W  commit destination register.
- cmt_data  in  XLEN  commit value.
- cmt_tag  in  ROB_TAG_W  tag of the committing entry.
- flush  in  1  mispredict flush.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset state: all regs = 0, all busy = 0, all tags = 0. Outputs: out_valid = 0, values/tags/offset = 0, rdy = 0.
- Reset overrides every other input in the same cycle.
- Handshake: an issue is accepted on iss_valid & iss_ready.
  - The bundle is registered; it appears on out_* the next cycle (latency 1).
  - The bundle holds stable while out_valid & !out_ready.
  - out_valid clears on out_ready without a new accept.
- Operand selection by opcode:
  - add/sub/sll/srl/mul/bne: src1 = rs1, src2 = rs2, offset = 0.
  - addi: src1 = rs1; src2 = imm (rdy2 = 1), offset = 0.
  - lw: src2 = rs1 (base); src1 unused (rdy1 = 1, v1 = 0); offset = imm.
  - sw: src1 = rs1, src2 = rs2, offset = imm.
  - li: v1 = 0 (rdy1 = 1), v2 = imm (rdy2 = 1).
  - Unknown opcode: both operands rdy = 1 with value 0.
- Register source lookup:
  - r0: rdy = 1, value 0.
  - Not busy: rdy = 1, value = reg.
  - Busy, and a commit this cycle has cmt_tag == tag[r] and cmt_idx == r: bypass, rdy = 1, value = cmt_data.
  - Otherwise: rdy = 0, q = tag[r], v = 0.
- Rename on accept (ops add/addi/sub/sll/srl/mul/lw/li with rd != 0): busy[rd] = 1, tag[rd] = iss_rob_tag. sw and bne do not rename.
- Sources read the mapping before the instruction's own rename, so rs == rd sees the old mapping.
- Commit:
  - reg[cmt_idx] = cmt_data, except when cmt_idx == 0 (ignored).
  - busy[cmt_idx] clears only if tag[cmt_idx] == cmt_tag; a newer rename keeps busy.
- Commit and rename to the same register in one cycle: data is written; busy = 1 and tag = new tag (rename wins).
- Flush: all busy = 0 and out_valid = 0. Any issue accept in that cycle is dropped (no rename, no bundle). A commit in the same cycle still writes data.

Decomposition:
- Package rob_pkg holds:
  - opcode constants;
  - XLEN and ROB_TAG_W defaults;
  - an operand-bundle struct typedef {v, q, rdy};
  - function writes_rd(op).
- Sub-module rename_table (busy/tag arrays, rename, commit clear, flush) is instantiated by rename_regfile. Data storage and operand muxing stay in the top level.

Test Plan:
- Reset, then issue add r1,r2,r3 -> next cycle out_valid = 1, v1 = v2 = 0, rdy1 = rdy2 = 1; busy[1] = 1, tag[1] = iss_rob_tag.
- Issue addi r5,r0,imm=7, tag 2; then add r6,r5,r5 -> out_q1 = out_q2 = 2, rdy = 0. Then commit r5 = 7 with tag 2 -> busy[5] = 0; a subsequent read of r5 gives 7.
- Same-cycle bypass: r4 busy with tag 3; commit (r4, 99, tag 3) while issuing sw r4,r4,imm=8 -> v1 = v2 = 99, rdy = 1, offset = 8.
- Stale commit: rename r7 to tag 1, then to tag 4; commit (r7, 5, tag 1) -> reg[7] = 5, busy[7] stays 1 with tag 4.
- Backpressure: hold out_ready = 0 with out_valid = 1 -> iss_ready = 0 and the bundle is stable for 3 cycles; the next issue is accepted the cycle after out_ready = 1.
- Flush with a concurrent issue, and rst asserted mid-stream -> all busy = 0, out_valid = 0, no rename from the dropped issue. After rst, all registers read 0.
